bcd_score_counter: RTL and testbench



---
 rtl/bcd_score_counter.sv | 145 ++++++++++++++
 tb/tb_bcd_score_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_counter.sv
// N-digit BCD up/down score/timer counter with load, clear, wrap or saturate,
// zero/max/win decodes and registered overflow/underflow pulses.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   clear, load       sync clear to 0 / sync load of load_val (nibbles > 9 -> 9)
//   load_val          BCD load value, nibble k = 10^k digit
//   inc, dec          count up / down one step (both high: no change)
//   digits            current count, BCD, nibble 0 = units
//   is_zero, is_max   count == 0 / every digit == 9
//   win               count >= WIN_SCORE (0 when WIN_SCORE == 0)
//   ovf, unf          one-cycle pulse on inc at max / dec at 0
module bcd_score_counter #(
  parameter int DIGITS    = 2,
  parameter bit WRAP      = 1'b1,
  parameter int WIN_SCORE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  inc,
  input  logic                  dec,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  is_zero,
  output logic                  is_max,
  output logic                  win,
  output logic                  ovf,
  output logic                  unf
);

  localparam int W = 4 * DIGITS;

  if ((DIGITS < 1) || (DIGITS > 6)) begin : g_bad_digits
    $error("bcd_score_counter: DIGITS must be 1..6");
  end

  if ((WIN_SCORE < 0) || (WIN_SCORE >= 10 ** DIGITS)) begin : g_bad_win
    $error("bcd_score_counter: WIN_SCORE out of range");
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);

  logic [W-1:0] digits_q, digits_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;

  logic [W-1:0] inc_v, dec_v, ld_v;
  logic         cy, bw;
  logic         win_gt, win_eq;

  // Ripple carry/borrow: cy stays set while every lower digit is 9,
  // bw while every lower digit is 0. After the last digit they give
  // the max and zero decodes.
  always_comb begin
    inc_v = digits_q;
    dec_v = digits_q;
    ld_v  = '0;
    cy    = 1'b1;
    bw    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (cy) begin
        inc_v[4*k +: 4] = (digits_q[4*k +: 4] == 4'd9) ?
                          4'd0 : digits_q[4*k +: 4] + 4'd1;
      end
      if (bw) begin
        dec_v[4*k +: 4] = (digits_q[4*k +: 4] == 4'd0) ?
                          4'd9 : digits_q[4*k +: 4] - 4'd1;
      end
      cy = cy & (digits_q[4*k +: 4] == 4'd9);
      bw = bw & (digits_q[4*k +: 4] == 4'd0);
      ld_v[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ?
                       4'd9 : load_val[4*k +: 4];
    end
  end

  assign is_max  = cy;
  assign is_zero = bw;

  always_comb begin
    digits_d = digits_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (clear) begin
      digits_d = '0;
    end else if (load) begin
      digits_d = ld_v;
    end else if (inc && !dec) begin
      // inc_v already rolls over to all zeros at max
      ovf_d    = cy;
      digits_d = (cy && !WRAP) ? digits_q : inc_v;
    end else if (dec && !inc) begin
      // dec_v already rolls under to all nines at zero
      unf_d    = bw;
      digits_d = (bw && !WRAP) ? digits_q : dec_v;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Decimal magnitude compare, most-significant digit first.
  always_comb begin
    win_gt = 1'b0;
    win_eq = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (win_eq) begin
        if (digits_q[4*k +: 4] > WIN_BCD[4*k +: 4]) begin
          win_gt = 1'b1;
          win_eq = 1'b0;
        end else if (digits_q[4*k +: 4] < WIN_BCD[4*k +: 4]) begin
          win_eq = 1'b0;
        end
      end
    end
  end

  assign win    = (WIN_SCORE != 0) && (win_gt || win_eq);
  assign digits = digits_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter: three configurations share one stimulus
// stream and are checked against an integer-valued reference model.
module tb_bcd_score_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, load, inc, dec;
  logic [11:0] load_val;

  logic [7:0]  a_dig;
  logic        a_z, a_m, a_w, a_o, a_u;
  logic [11:0] b_dig;
  logic        b_z, b_m, b_w, b_o, b_u;
  logic [11:0] c_dig;
  logic        c_z, c_m, c_w, c_o, c_u;

  bcd_score_counter #(.DIGITS(2), .WRAP(1'b1), .WIN_SCORE(11)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_val(load_val[7:0]), .inc(inc), .dec(dec),
    .digits(a_dig), .is_zero(a_z), .is_max(a_m), .win(a_w),
    .ovf(a_o), .unf(a_u));

  bcd_score_counter #(.DIGITS(3), .WRAP(1'b0), .WIN_SCORE(0)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_val(load_val), .inc(inc), .dec(dec),
    .digits(b_dig), .is_zero(b_z), .is_max(b_m), .win(b_w),
    .ovf(b_o), .unf(b_u));

  bcd_score_counter #(.DIGITS(3), .WRAP(1'b1), .WIN_SCORE(500)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_val(load_val), .inc(inc), .dec(dec),
    .digits(c_dig), .is_zero(c_z), .is_max(c_m), .win(c_w),
    .ovf(c_o), .unf(c_u));

  int n_cmp = 0;
  int n_bad = 0;

  // model state: plain decimal counts and pulse flags
  int mA, mB, mC;
  bit oA, uA, oB, uB, oC, uC;

  function automatic int p10(input int d);
    int r;
    r = 1;
    for (int k = 0; k < d; k++) r = r * 10;
    return r;
  endfunction

  function automatic int clampv(input int d, input logic [11:0] lv);
    int r, p, n;
    r = 0;
    p = 1;
    for (int k = 0; k < d; k++) begin
      n = int'(lv[4*k +: 4]);
      if (n > 9) n = 9;
      r = r + n * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int tob(input int v);
    int r, t;
    r = 0;
    t = v;
    for (int k = 0; k < 6; k++) begin
      r = r | ((t % 10) << (4 * k));
      t = t / 10;
    end
    return r;
  endfunction

  task automatic ck(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mstep(input int d, input bit wr, inout int v,
                       output bit o, output bit u);
    int mx;
    mx = p10(d) - 1;
    o = 1'b0;
    u = 1'b0;
    if (clear) v = 0;
    else if (load) v = clampv(d, load_val);
    else if (inc && !dec) begin
      if (v == mx) begin
        o = 1'b1;
        if (wr) v = 0;
      end else v = v + 1;
    end else if (dec && !inc) begin
      if (v == 0) begin
        u = 1'b1;
        if (wr) v = mx;
      end else v = v - 1;
    end
  endtask

  task automatic chk_all();
    ck("A.digits", int'(a_dig), tob(mA));
    ck("A.is_zero", int'(a_z), int'(mA == 0));
    ck("A.is_max", int'(a_m), int'(mA == 99));
    ck("A.win", int'(a_w), int'(mA >= 11));
    ck("A.ovf", int'(a_o), int'(oA));
    ck("A.unf", int'(a_u), int'(uA));
    ck("B.digits", int'(b_dig), tob(mB));
    ck("B.is_zero", int'(b_z), int'(mB == 0));
    ck("B.is_max", int'(b_m), int'(mB == 999));
    ck("B.win", int'(b_w), 0);
    ck("B.ovf", int'(b_o), int'(oB));
    ck("B.unf", int'(b_u), int'(uB));
    ck("C.digits", int'(c_dig), tob(mC));
    ck("C.is_zero", int'(c_z), int'(mC == 0));
    ck("C.is_max", int'(c_m), int'(mC == 999));
    ck("C.win", int'(c_w), int'(mC >= 500));
    ck("C.ovf", int'(c_o), int'(oC));
    ck("C.unf", int'(c_u), int'(uC));
  endtask

  // Inputs change on the falling edge; outputs are checked on the next one.
  task automatic cyc(input bit c, input bit l, input logic [11:0] lv,
                     input bit i, input bit d);
    clear    = c;
    load     = l;
    load_val = lv;
    inc      = i;
    dec      = d;
    @(posedge clk);
    mstep(2, 1'b1, mA, oA, uA);
    mstep(3, 1'b0, mB, oB, uB);
    mstep(3, 1'b1, mC, oC, uC);
    @(negedge clk);
    chk_all();
  endtask

  typedef struct {
    bit          c;
    bit          l;
    logic [11:0] lv;
    bit          i;
    bit          d;
    logic [7:0]  ex;
    bit          eo;
    bit          eu;
    bit          ew;
  } vec_t;

  vec_t tbl[13];

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    load     = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    load_val = '0;
    mA = 0; mB = 0; mC = 0;
    oA = 0; uA = 0; oB = 0; uB = 0; oC = 0; uC = 0;

    //        c  l  lv       i  d  ex     eo eu ew
    tbl[0]  = '{0, 1, 12'h009, 0, 0, 8'h09, 0, 0, 0};
    tbl[1]  = '{0, 0, 12'h000, 1, 0, 8'h10, 0, 0, 0};
    tbl[2]  = '{0, 0, 12'h000, 1, 0, 8'h11, 0, 0, 1};
    tbl[3]  = '{0, 1, 12'h019, 0, 0, 8'h19, 0, 0, 1};
    tbl[4]  = '{0, 0, 12'h000, 1, 0, 8'h20, 0, 0, 1};
    tbl[5]  = '{0, 1, 12'h042, 0, 0, 8'h42, 0, 0, 1};
    tbl[6]  = '{1, 1, 12'h037, 1, 0, 8'h00, 0, 0, 0};
    tbl[7]  = '{0, 1, 12'h037, 1, 0, 8'h37, 0, 0, 1};
    tbl[8]  = '{0, 0, 12'h000, 1, 1, 8'h37, 0, 0, 1};
    tbl[9]  = '{0, 1, 12'h0AF, 0, 0, 8'h99, 0, 0, 1};
    tbl[10] = '{0, 0, 12'h000, 1, 0, 8'h00, 1, 0, 0};
    tbl[11] = '{0, 0, 12'h000, 0, 1, 8'h99, 0, 1, 1};
    tbl[12] = '{1, 0, 12'h000, 0, 0, 8'h00, 0, 0, 0};

    repeat (2) @(negedge clk);
    chk_all();
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 13; n++) begin
      cyc(tbl[n].c, tbl[n].l, tbl[n].lv, tbl[n].i, tbl[n].d);
      ck($sformatf("tbl%0d.digits", n), int'(a_dig), int'(tbl[n].ex));
      ck($sformatf("tbl%0d.ovf", n), int'(a_o), int'(tbl[n].eo));
      ck($sformatf("tbl%0d.unf", n), int'(a_u), int'(tbl[n].eu));
      ck($sformatf("tbl%0d.win", n), int'(a_w), int'(tbl[n].ew));
    end

    // asynchronous reset between edges
    cyc(0, 1, 12'h555, 0, 0);
    #2 reset = 1'b1;
    #1;
    ck("async.A.digits", int'(a_dig), 0);
    ck("async.A.is_zero", int'(a_z), 1);
    ck("async.C.digits", int'(c_dig), 0);
    mA = 0; mB = 0; mC = 0;
    oA = 0; uA = 0; oB = 0; uB = 0; oC = 0; uC = 0;
    @(negedge clk);
    reset = 1'b0;
    chk_all();

    // 99 increments to max, then wrap with a single ovf pulse
    for (int n = 0; n < 99; n++) cyc(0, 0, 12'h000, 1, 0);
    ck("inc99.digits", int'(a_dig), 32'h99);
    ck("inc99.is_max", int'(a_m), 1);
    cyc(0, 0, 12'h000, 1, 0);
    ck("wrap.digits", int'(a_dig), 0);
    ck("wrap.ovf", int'(a_o), 1);
    cyc(0, 0, 12'h000, 0, 0);
    ck("wrap.ovf_drop", int'(a_o), 0);

    // 3-digit saturate vs wrap at both ends
    cyc(0, 1, 12'h001, 0, 0);
    cyc(0, 0, 12'h000, 0, 1);
    ck("B.dec1", int'(b_dig), 0);
    cyc(0, 0, 12'h000, 0, 1);
    ck("B.sat0", int'(b_dig), 0);
    ck("B.unf", int'(b_u), 1);
    ck("C.wrap0", int'(c_dig), 32'h999);
    ck("C.unf", int'(c_u), 1);
    cyc(0, 1, 12'h999, 0, 0);
    ck("B.load_noovf", int'(b_o), 0);
    cyc(0, 0, 12'h000, 1, 0);
    ck("B.sat999", int'(b_dig), 32'h999);
    ck("B.ovf", int'(b_o), 1);
    ck("C.wrap999", int'(c_dig), 0);
    cyc(0, 0, 12'h000, 1, 0);
    ck("B.ovf_sustain", int'(b_o), 1);
    ck("C.ovf_drop", int'(c_o), 0);
    cyc(0, 1, 12'h100, 0, 0);
    cyc(0, 0, 12'h000, 0, 1);
    ck("C.borrow", int'(c_dig), 32'h099);
    cyc(0, 1, 12'h000, 0, 0);
    cyc(0, 0, 12'h000, 0, 1);
    ck("C.under", int'(c_dig), 32'h999);
    ck("C.under_unf", int'(c_u), 1);

    // randomized stream against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cyc(r < 2, (r >= 2) && (r < 12), 12'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
